// File: rtl/dlfloat_pkg.sv
// Shared constants and state encoding for the DLFloat MAC job controller.
package dlfloat_pkg;

    localparam int DLF_W = 16;
    localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
    localparam logic [DLF_W-1:0] DLF_ONE  = 16'h3E00;

    // Default accumulator latency of the attached MAC, in cycles.
    localparam int MAC_LAT_DEF = 3;

    // Explicit encodings keep the state register compatible with older dumps.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // True for an exact all-zero operand word.
    function automatic logic dlf_is_zero(input logic [DLF_W-1:0] v);
        return v == DLF_ZERO;
    endfunction

endpackage

// File: rtl/dlfloat_mac_ctrl.sv
// DLFloat multiply-accumulate job controller.
// Accepts a job of 'len' operand pairs, clears the external MAC, streams the
// pairs into it, waits MAC_LAT cycles for the accumulator to settle and
// presents the captured result on a valid/ready handshake.
// Optional build macro: DLF_MAC_ZERO_SKIP_EN -- pairs with a zero operand are
// accepted and counted but not issued to the MAC (out_cnt counts issued pairs).
module dlfloat_mac_ctrl
    import dlfloat_pkg::*;
#(
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int LEN_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DLF_W-1:0] in_a,
    input  logic [DLF_W-1:0] in_b,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [DLF_W-1:0] mac_a,
    output logic [DLF_W-1:0] mac_b,
    input  logic [DLF_W-1:0] mac_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DLF_W-1:0] out_data,
    output logic [LEN_W-1:0] out_cnt
);

    localparam int DRN_W = $clog2(MAC_LAT + 2);

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] pair_cnt;
    logic [DRN_W-1:0] drain;
    logic             hs;
    logic             issue;
    logic             last_pair;

    assign hs        = in_valid & in_ready;
    assign last_pair = (pair_cnt == len_q - 1'b1);

`ifdef DLF_MAC_ZERO_SKIP_EN
    assign issue = hs & ~dlf_is_zero(in_a) & ~dlf_is_zero(in_b);
`else
    assign issue = hs;
`endif

    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Job sequencing, operand registering, pair/drain counting and result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            pair_cnt <= '0;
            drain    <= '0;
            in_ready <= 1'b0;
            mac_clr  <= 1'b0;
            mac_en   <= 1'b0;
            mac_a    <= '0;
            mac_b    <= '0;
            out_data <= '0;
            out_cnt  <= '0;
        end else begin
            mac_clr <= 1'b0;
            mac_en  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= len;
                        mac_clr <= 1'b1;
                        state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    pair_cnt <= '0;
                    out_cnt  <= '0;
                    if (len_q == '0) begin
                        out_data <= DLF_ZERO;
                        state    <= ST_DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    if (hs) begin
                        mac_a    <= in_a;
                        mac_b    <= in_b;
                        mac_en   <= issue;
                        // Leaving FEED on the len-th pair means the count stops
                        // at len and never wraps, even for the all-ones length.
                        pair_cnt <= pair_cnt + 1'b1;
                        if (issue) begin
                            out_cnt <= out_cnt + 1'b1;
                        end
                        if (last_pair) begin
                            in_ready <= 1'b0;
                            drain    <= DRN_W'(MAC_LAT);
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain == '0) begin
                        out_data <= mac_c;
                        state    <= ST_DONE;
                    end else begin
                        drain <= drain - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_mac_ctrl.sv
// Self-checking bench for dlfloat_mac_ctrl: directed jobs against a
// behavioural MAC, expected results queued at job start and compared by a
// separate monitor on each out_valid/out_ready handshake.
module tb_dlfloat_mac_ctrl;
    import dlfloat_pkg::*;

    localparam int MAC_LAT = 3;
    localparam int LEN_W   = 8;
`ifdef DLF_MAC_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_a = '0;
    logic [15:0]      in_b = '0;
    logic             mac_clr;
    logic             mac_en;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [15:0]      mac_c;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [15:0]      out_data;
    logic [LEN_W-1:0] out_cnt;

    dlfloat_mac_ctrl #(.MAC_LAT(MAC_LAT), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b),
        .mac_c(mac_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- DLFloat <-> real helpers ----------------
    function automatic real d2r(input logic [15:0] v);
        real r;
        int  e;
        if (v[14:0] == 15'd0) return 0.0;
        r = 1.0 + real'(v[8:0]) / 512.0;
        e = int'(v[14:9]) - 31;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return v[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2d(input real x);
        real  r;
        int   e;
        int   mi;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        r = s ? -x : x;
        e = 31;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        mi = $rtoi((r - 1.0) * 512.0 + 0.5);
        if (mi == 512) begin mi = 0; e++; end
        return {s, 6'(e), 9'(mi)};
    endfunction

    // ---------------- behavioural MAC, MAC_LAT latency ----------------
    logic [32:0] dly [0:MAC_LAT-2];
    real         acc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 0.0;
            for (int i = 0; i < MAC_LAT - 1; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {mac_en, mac_a, mac_b};
            for (int i = 1; i < MAC_LAT - 1; i++) dly[i] <= dly[i-1];
            if (mac_clr)
                acc <= 0.0;
            else if (dly[MAC_LAT-2][32])
                acc <= acc + d2r(dly[MAC_LAT-2][31:16]) * d2r(dly[MAC_LAT-2][15:0]);
        end
    end

    assign mac_c = r2d(acc);

    // ---------------- scoreboard and counters ----------------
    typedef struct {
        logic [15:0]      data;
        logic [LEN_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc = 0, en_total = 0, clr_total = 0, ir_total = 0, ovl_total = 0;
    int   res_total = 0, last_en_cyc = 0, ov_rise_cyc = 0;
    logic prev_ov = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: per-cycle bookkeeping and result comparison on each handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                cyc++;
                if (mac_en) begin en_total++; last_en_cyc = cyc; end
                if (mac_clr) clr_total++;
                if (in_ready) ir_total++;
                if (mac_clr && mac_en) ovl_total++;
                if (in_ready && !busy) ovl_total++;
                if (out_valid && !prev_ov) ov_rise_cyc = cyc;
                prev_ov = out_valid;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", 32'(out_data), 32'(e.data));
                        chk("out_cnt", 32'(out_cnt), 32'(e.cnt));
                    end
                    res_total++;
                end
            end else begin
                prev_ov = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d, input logic [LEN_W-1:0] c);
        exp_t e;
        e.data = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic start_job(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_result(input int want);
        for (int i = 0; i < 300; i++) begin
            if (res_total >= want) return;
            tick();
        end
        chk("result_timeout", 32'(res_total), 32'(want));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
        chk({tag, "_mac_clr"},   32'(mac_clr),   32'd0);
        chk({tag, "_mac_en"},    32'(mac_en),    32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_mac_a"},     32'(mac_a),     32'd0);
        chk({tag, "_mac_b"},     32'(mac_b),     32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_cnt"},   32'(out_cnt),   32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int want, en0, clr0, ir0;

        #2 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Three unit products streamed back-to-back: 1+1+1 = 3.0.
        want = res_total + 1; en0 = en_total; clr0 = clr_total;
        push(16'h4100, 8'd3);
        start_job(8'd3);
        for (int i = 0; i < 3; i++) send(DLF_ONE, DLF_ONE);
        in_valid = 1'b0;
        wait_result(want);
        chk("t1_mac_clr_pulses", 32'(clr_total - clr0), 32'd1);
        chk("t1_mac_en_cycles", 32'(en_total - en0), 32'd3);

        // Two pairs with a two-cycle input gap; result 2.0.
        want = res_total + 1; en0 = en_total;
        push(16'h4000, 8'd2);
        start_job(8'd2);
        send(DLF_ONE, DLF_ONE);
        in_valid = 1'b0;
        tick();
        tick();
        send(DLF_ONE, DLF_ONE);
        in_valid = 1'b0;
        wait_result(want);
        chk("t2_mac_en_cycles", 32'(en_total - en0), 32'd2);
        // out_valid rises MAC_LAT cycles after the last mac_en cycle ends.
        chk("t2_latency", 32'(ov_rise_cyc - last_en_cyc), 32'(MAC_LAT + 1));

        // Empty job: DONE two cycles after start, zero result, no in_ready.
        want = res_total + 1; ir0 = ir_total;
        push(16'h0000, 8'd0);
        start_job(8'd0);
        tick();
        chk("t3_done_at_two", 32'(out_valid), 32'd1);
        wait_result(want);
        chk("t3_in_ready_never", 32'(ir_total - ir0), 32'd0);

        // Back-pressure in DONE with start pulses that must be ignored.
        out_ready = 1'b0;
        want = res_total + 1;
        push(16'h4000, 8'd1);
        start_job(8'd1);
        send(16'h4000, DLF_ONE);
        in_valid = 1'b0;
        for (int i = 0; i < 30 && !out_valid; i++) tick();
        for (int i = 0; i < 5; i++) begin
            start = (i % 2 == 1);
            tick();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_data", 32'(out_data), 32'h4000);
            chk("t4_hold_cnt", 32'(out_cnt), 32'd1);
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        wait_result(want);
        chk("t4_start_in_done_ignored", 32'(busy), 32'd0);

        // Reset mid-FEED after one of four pairs.
        start_job(8'd4);
        send(DLF_ONE, DLF_ONE);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midjob");
        void'(sb.pop_back());
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // First job after reset: 2.0 * 1.0 = 2.0.
        want = res_total + 1; clr0 = clr_total;
        push(16'h4000, 8'd1);
        start_job(8'd1);
        send(16'h4000, DLF_ONE);
        in_valid = 1'b0;
        wait_result(want);
        chk("t5_mac_clr_pulses", 32'(clr_total - clr0), 32'd1);

        // Zero operands: skipped when the skip option is built in, else issued.
        want = res_total + 1; en0 = en_total;
        push(16'h3E00, SKIP ? 8'd1 : 8'd3);
        start_job(8'd3);
        send(16'h0000, DLF_ONE);
        send(DLF_ONE, DLF_ONE);
        send(DLF_ONE, 16'h0000);
        in_valid = 1'b0;
        wait_result(want);
        chk("t6_mac_en_cycles", 32'(en_total - en0), SKIP ? 32'd1 : 32'd3);

        // Maximum length: 255 unit products = 255.0 = 0x4DFC.
        want = res_total + 1; en0 = en_total;
        push(16'h4DFC, 8'd255);
        start_job(8'd255);
        for (int i = 0; i < 255; i++) send(DLF_ONE, DLF_ONE);
        in_valid = 1'b0;
        wait_result(want);
        chk("t7_mac_en_cycles", 32'(en_total - en0), 32'd255);

        tick();
        chk("protocol_overlaps", 32'(ovl_total), 32'd0);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
